// File: rtl/vm1_bus_ctl.sv
// VM1 bus interface unit: runs one handshaked cycle on the synchronous system bus per request.
// Optional feature macro VM1_ODD_ADDR_TRAP_EN: word access at an odd address traps to ERR without a bus cycle.
module vm1_bus_ctl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic        req_byte,
    input  logic [15:0] dba,
    input  logic [15:0] dbo,
    output logic [15:0] dbi,
    output logic        busy,
    output logic        done,
    output logic        buserr,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    output logic [1:0]  bus_sel,
    output logic        bus_we,
    output logic        bus_stb,
    input  logic [15:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2,
        S_ERR    = 2'd3
    } state_e;

`ifdef VM1_ODD_ADDR_TRAP_EN
    localparam bit ODD_TRAP = 1'b1;
`else
    localparam bit ODD_TRAP = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              byte_q, byte_d;
    logic              we_q, we_d;
    logic [15:0]       dbi_q, dbi_d;
    logic [15:0]       rd_mux;

    // Byte reads return the addressed lane right-justified and zero-extended.
    always_comb begin
        rd_mux = bus_rdata;
        if (byte_q) begin
            rd_mux = {8'h00, addr_q[0] ? bus_rdata[15:8] : bus_rdata[7:0]};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        byte_d  = byte_q;
        we_d    = we_q;
        dbi_d   = dbi_q;
        case (state_q)
            S_IDLE: begin
                if (req_rd && req_wr) begin
                    state_d = S_ERR;
                end else if (req_rd || req_wr) begin
                    addr_d  = dba;
                    wdata_d = dbo;
                    byte_d  = req_byte;
                    we_d    = req_wr;
                    cnt_d   = '0;
                    if (ODD_TRAP && !req_byte && dba[0]) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_ACTIVE;
                    end
                end
            end
            S_ACTIVE: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Ack takes priority over a timeout landing in the same cycle.
                if (bus_ack) begin
                    state_d = S_DONE;
                    if (!we_q) begin
                        dbi_d = rd_mux;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            byte_q  <= 1'b0;
            we_q    <= 1'b0;
            dbi_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            byte_q  <= byte_d;
            we_q    <= we_d;
            dbi_q   <= dbi_d;
        end
    end

    // Bus outputs decode from registered state only, so an async reset drops them at once.
    logic active;
    always_comb begin
        active    = (state_q == S_ACTIVE);
        bus_stb   = active;
        bus_we    = active && we_q;
        bus_addr  = active ? {addr_q[15:1], 1'b0} : 16'h0000;
        bus_sel   = 2'b00;
        bus_wdata = 16'h0000;
        if (active) begin
            if (byte_q) begin
                bus_sel   = addr_q[0] ? 2'b10 : 2'b01;
                bus_wdata = {wdata_q[7:0], wdata_q[7:0]};
            end else begin
                bus_sel   = 2'b11;
                bus_wdata = wdata_q;
            end
        end
        busy   = (state_q != S_IDLE);
        done   = (state_q == S_DONE);
        buserr = (state_q == S_ERR);
        dbi    = dbi_q;
    end

endmodule
